// File: rtl/norm1_mul_pipe.sv
// Pipelined din0 x din1 multiplier with per-transaction signed/unsigned mode,
// optional output saturation, overflow flag and valid/ready flow control.

module norm1_mul_pipe #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 18,
    parameter int din1_WIDTH = 18,
    parameter int dout_WIDTH = 36,
    parameter int SAT        = 0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  sgn,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf
);
    localparam int P = din0_WIDTH + din1_WIDTH;

    logic                  stall_s;
    logic                  adv_s;
    logic [P-1:0]          op0_s;
    logic [P-1:0]          op1_s;
    logic [P-1:0]          mul_prod_s;
    logic                  fmt_valid_s;
    logic                  fmt_sgn_s;
    logic [P-1:0]          fmt_prod_s;
    logic [dout_WIDTH-1:0] fin_dout_s;
    logic                  fin_ovf_s;
    logic                  out_valid_q;
    logic                  out_valid_d;
    logic [dout_WIDTH-1:0] dout_q;
    logic [dout_WIDTH-1:0] dout_d;
    logic                  ovf_q;
    logic                  ovf_d;

    assign stall_s  = out_valid_q & ~out_ready;
    assign adv_s    = ~stall_s;
    assign in_ready = adv_s;

    // Extend both operands to P bits; the low P bits of the product are exact in either mode.
    always_comb begin
        op0_s      = {{(P-din0_WIDTH){sgn & din0[din0_WIDTH-1]}}, din0};
        op1_s      = {{(P-din1_WIDTH){sgn & din1[din1_WIDTH-1]}}, din1};
        mul_prod_s = op0_s * op1_s;
    end

    generate
        if (NUM_STAGE == 1) begin : g_direct
            // Single stage: the output register captures the formatted product directly.
            always_comb begin
                fmt_valid_s = in_valid & in_ready;
                fmt_sgn_s   = sgn;
                fmt_prod_s  = mul_prod_s;
            end
        end else begin : g_pipe
            localparam int NP = NUM_STAGE - 1;

            logic [NP-1:0] vld_q;
            logic [NP-1:0] vld_d;
            logic [NP-1:0] sgn_q;
            logic [NP-1:0] sgn_d;
            logic [P-1:0]  prod_q [NP];
            logic [P-1:0]  prod_d [NP];

            // Product stages shift together; bubbles travel like data but carry no payload update.
            always_comb begin
                vld_d = vld_q;
                sgn_d = sgn_q;
                for (int k = 0; k < NP; k++) begin
                    prod_d[k] = prod_q[k];
                end
                if (adv_s) begin
                    vld_d[0] = in_valid & in_ready;
                    if (in_valid & in_ready) begin
                        sgn_d[0]  = sgn;
                        prod_d[0] = mul_prod_s;
                    end else begin
                        sgn_d[0]  = sgn_q[0];
                        prod_d[0] = prod_q[0];
                    end
                    for (int k = 1; k < NP; k++) begin
                        vld_d[k] = vld_q[k-1];
                        if (vld_q[k-1]) begin
                            sgn_d[k]  = sgn_q[k-1];
                            prod_d[k] = prod_q[k-1];
                        end else begin
                            sgn_d[k]  = sgn_q[k];
                            prod_d[k] = prod_q[k];
                        end
                    end
                end else begin
                    vld_d = vld_q;
                end
            end

            // Product stage registers.
            always_ff @(posedge ap_clk) begin
                if (ap_rst) begin
                    vld_q <= {NP{1'b0}};
                    sgn_q <= {NP{1'b0}};
                    for (int k = 0; k < NP; k++) begin
                        prod_q[k] <= {P{1'b0}};
                    end
                end else begin
                    vld_q <= vld_d;
                    sgn_q <= sgn_d;
                    for (int k = 0; k < NP; k++) begin
                        prod_q[k] <= prod_d[k];
                    end
                end
            end

            // Oldest product stage feeds the result formatter.
            always_comb begin
                fmt_valid_s = vld_q[NP-1];
                fmt_sgn_s   = sgn_q[NP-1];
                fmt_prod_s  = prod_q[NP-1];
            end
        end
    endgenerate

    generate
        if (dout_WIDTH >= P) begin : g_wide
            // Result is wide enough for any product: plain sign/zero extension.
            always_comb begin
                if (fmt_sgn_s) begin
                    fin_dout_s = dout_WIDTH'($signed(fmt_prod_s));
                end else begin
                    fin_dout_s = dout_WIDTH'(fmt_prod_s);
                end
                fin_ovf_s = 1'b0;
            end
        end else begin : g_narrow
            localparam int HW = P - dout_WIDTH;

            logic [HW-1:0]         hi_s;
            logic [dout_WIDTH-1:0] lo_s;

            // Overflow when the discarded bits are not an extension of the kept bits.
            always_comb begin
                hi_s = fmt_prod_s[P-1:dout_WIDTH];
                lo_s = fmt_prod_s[dout_WIDTH-1:0];
                if (fmt_sgn_s) begin
                    fin_ovf_s = (hi_s != {HW{lo_s[dout_WIDTH-1]}});
                end else begin
                    fin_ovf_s = (hi_s != {HW{1'b0}});
                end
                if ((SAT != 0) && fin_ovf_s) begin
                    if (fmt_sgn_s) begin
                        if (fmt_prod_s[P-1]) begin
                            fin_dout_s = {1'b1, {(dout_WIDTH-1){1'b0}}};
                        end else begin
                            fin_dout_s = {1'b0, {(dout_WIDTH-1){1'b1}}};
                        end
                    end else begin
                        fin_dout_s = {dout_WIDTH{1'b1}};
                    end
                end else begin
                    fin_dout_s = lo_s;
                end
            end
        end
    endgenerate

    // Output stage: dout/ovf only change when a valid result moves in.
    always_comb begin
        if (adv_s) begin
            out_valid_d = fmt_valid_s;
            if (fmt_valid_s) begin
                dout_d = fin_dout_s;
                ovf_d  = fin_ovf_s;
            end else begin
                dout_d = dout_q;
                ovf_d  = ovf_q;
            end
        end else begin
            out_valid_d = out_valid_q;
            dout_d      = dout_q;
            ovf_d       = ovf_q;
        end
    end

    // Output registers.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            out_valid_q <= 1'b0;
            dout_q      <= {dout_WIDTH{1'b0}};
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign ovf       = ovf_q;

    norm1_mul_pipe_chk #(
        .ID (ID),
        .W  (dout_WIDTH)
    ) u_chk (
        .clk       (ap_clk),
        .rst       (ap_rst),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .ovf       (ovf)
    );

endmodule

// Handshake properties of norm1_mul_pipe.
module norm1_mul_pipe_chk #(
    parameter int ID = 1,
    parameter int W  = 36
) (
    input logic         clk,
    input logic         rst,
    input logic         in_ready,
    input logic         out_valid,
    input logic         out_ready,
    input logic [W-1:0] dout,
    input logic         ovf
);
    a_ready: assert property (@(posedge clk) disable iff (rst)
        in_ready == !(out_valid && !out_ready))
        else $error("norm1_mul_pipe[%0d]: in_ready differs from ~stall", ID);

    a_hold: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(dout) && $stable(ovf)))
        else $error("norm1_mul_pipe[%0d]: output changed while stalled", ID);

    a_reset: assert property (@(posedge clk)
        rst |=> (!out_valid && (dout == {W{1'b0}}) && !ovf))
        else $error("norm1_mul_pipe[%0d]: outputs not cleared by reset", ID);
endmodule

// File: tb/tb_norm1_mul_pipe.sv
// Directed bench for norm1_mul_pipe: five configurations share one stimulus stream.

module tb_norm1_mul_pipe;
    logic        clk;
    logic        ap_rst;
    logic        in_valid;
    logic        out_ready;
    logic [17:0] din0;
    logic [17:0] din1;
    logic        sgn;

    logic        def_in_ready, def_out_valid, def_ovf;
    logic [35:0] def_dout;
    logic        sat_in_ready, sat_out_valid, sat_ovf;
    logic [15:0] sat_dout;
    logic        trn_in_ready, trn_out_valid, trn_ovf;
    logic [15:0] trn_dout;
    logic        n1_in_ready, n1_out_valid, n1_ovf;
    logic [35:0] n1_dout;
    logic        n8_in_ready, n8_out_valid, n8_ovf;
    logic [35:0] n8_dout;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [17:0] d0;
        logic [17:0] d1;
        logic        sg;
        logic [35:0] e36;
        logic [15:0] es;
        logic        os;
        logic [15:0] et;
        logic        ot;
    } vec_t;

    vec_t vecs [10];

    norm1_mul_pipe #(.ID(1), .NUM_STAGE(3), .dout_WIDTH(36), .SAT(0)) u_def (
        .ap_clk(clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(def_in_ready),
        .din0(din0), .din1(din1), .sgn(sgn), .out_valid(def_out_valid),
        .out_ready(out_ready), .dout(def_dout), .ovf(def_ovf));

    norm1_mul_pipe #(.ID(2), .NUM_STAGE(3), .dout_WIDTH(16), .SAT(1)) u_sat16 (
        .ap_clk(clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(sat_in_ready),
        .din0(din0), .din1(din1), .sgn(sgn), .out_valid(sat_out_valid),
        .out_ready(out_ready), .dout(sat_dout), .ovf(sat_ovf));

    norm1_mul_pipe #(.ID(3), .NUM_STAGE(3), .dout_WIDTH(16), .SAT(0)) u_trn16 (
        .ap_clk(clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(trn_in_ready),
        .din0(din0), .din1(din1), .sgn(sgn), .out_valid(trn_out_valid),
        .out_ready(out_ready), .dout(trn_dout), .ovf(trn_ovf));

    norm1_mul_pipe #(.ID(4), .NUM_STAGE(1), .dout_WIDTH(36), .SAT(0)) u_n1 (
        .ap_clk(clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(n1_in_ready),
        .din0(din0), .din1(din1), .sgn(sgn), .out_valid(n1_out_valid),
        .out_ready(out_ready), .dout(n1_dout), .ovf(n1_ovf));

    norm1_mul_pipe #(.ID(5), .NUM_STAGE(8), .dout_WIDTH(36), .SAT(0)) u_n8 (
        .ap_clk(clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(n8_in_ready),
        .din0(din0), .din1(din1), .sgn(sgn), .out_valid(n8_out_valid),
        .out_ready(out_ready), .dout(n8_dout), .ovf(n8_ovf));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // One transaction from a negedge; every instance is checked at its own latency.
    task automatic apply_vec(input int i);
        vec_t  v;
        string tag;
        v         = vecs[i];
        tag       = $sformatf("v%0d", i);
        din0      = v.d0;
        din1      = v.d1;
        sgn       = v.sg;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            check_eq({tag, "_def_valid"}, def_out_valid, (c == 3));
            if (c == 1) begin
                check_eq({tag, "_n1_valid"}, n1_out_valid, 1);
                check_eq({tag, "_n1_dout"}, n1_dout, v.e36);
                check_eq({tag, "_n1_ovf"}, n1_ovf, 0);
            end
            if (c == 3) begin
                check_eq({tag, "_def_dout"}, def_dout, v.e36);
                check_eq({tag, "_def_ovf"}, def_ovf, 0);
                check_eq({tag, "_sat_dout"}, sat_dout, v.es);
                check_eq({tag, "_sat_ovf"}, sat_ovf, v.os);
                check_eq({tag, "_trn_dout"}, trn_dout, v.et);
                check_eq({tag, "_trn_ovf"}, trn_ovf, v.ot);
            end
            if (c == 8) begin
                check_eq({tag, "_n8_valid"}, n8_out_valid, 1);
                check_eq({tag, "_n8_dout"}, n8_dout, v.e36);
                check_eq({tag, "_n8_ovf"}, n8_ovf, 0);
            end
        end
    endtask

    // Five back-to-back inputs with out_ready low for four cycles from the first result.
    task automatic run_backpressure();
        logic [35:0] prev_dout;
        logic        prev_stall;
        logic [35:0] exp_v;
        int          sent;
        int          recv;
        prev_dout  = 36'h0;
        prev_stall = 1'b0;
        sent       = 0;
        recv       = 0;
        for (int k = 0; k < 24; k++) begin
            out_ready = !((k >= 3) && (k <= 6));
            in_valid  = (sent < 5);
            din0      = 18'(sent + 1);
            din1      = 18'(256 + sent);
            sgn       = 1'b0;
            #1;
            if (prev_stall) begin
                check_eq("bp_hold_valid", def_out_valid, 1);
                check_eq("bp_hold_dout", def_dout, prev_dout);
            end
            if ((k >= 3) && (k <= 6)) begin
                check_eq("bp_in_ready", def_in_ready, 0);
            end
            if (def_out_valid && out_ready) begin
                if (recv < 5) begin
                    exp_v = 36'((recv + 1) * (256 + recv));
                    check_eq($sformatf("bp_dout%0d", recv), def_dout, exp_v);
                end else begin
                    check_eq("bp_extra_result", recv, 4);
                end
                recv++;
            end
            if (in_valid && def_in_ready) begin
                sent++;
            end
            prev_stall = def_out_valid && !out_ready;
            prev_dout  = def_dout;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_eq("bp_sent", sent, 5);
        check_eq("bp_recv", recv, 5);
    endtask

    initial begin
        vecs[0] = '{18'h3FFFF, 18'h3FFFF, 1'b0, 36'hFFFF80001, 16'hFFFF, 1'b1, 16'h0001, 1'b1};
        vecs[1] = '{18'h20000, 18'h3FFFF, 1'b1, 36'h000020000, 16'h7FFF, 1'b1, 16'h0000, 1'b1};
        vecs[2] = '{18'h3FFFE, 18'h00003, 1'b1, 36'hFFFFFFFFA, 16'hFFFA, 1'b0, 16'hFFFA, 1'b0};
        vecs[3] = '{18'h0012C, 18'h0012C, 1'b1, 36'h000015F90, 16'h7FFF, 1'b1, 16'h5F90, 1'b1};
        vecs[4] = '{18'h0012C, 18'h0012C, 1'b0, 36'h000015F90, 16'hFFFF, 1'b1, 16'h5F90, 1'b1};
        vecs[5] = '{18'h00064, 18'h3FF9C, 1'b1, 36'hFFFFFD8F0, 16'hD8F0, 1'b0, 16'hD8F0, 1'b0};
        vecs[6] = '{18'h0FFFF, 18'h00001, 1'b0, 36'h00000FFFF, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0};
        vecs[7] = '{18'h38000, 18'h00001, 1'b1, 36'hFFFFF8000, 16'h8000, 1'b0, 16'h8000, 1'b0};
        vecs[8] = '{18'h37FFF, 18'h00001, 1'b1, 36'hFFFFF7FFF, 16'h8000, 1'b1, 16'h7FFF, 1'b1};
        vecs[9] = '{18'h10000, 18'h00001, 1'b0, 36'h000010000, 16'hFFFF, 1'b1, 16'h0000, 1'b1};

        ap_rst    = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        din0      = 18'h0;
        din1      = 18'h0;
        sgn       = 1'b0;
        repeat (3) @(negedge clk);
        ap_rst = 1'b0;
        check_eq("rst_def_valid", def_out_valid, 0);
        check_eq("rst_def_dout", def_dout, 0);
        check_eq("rst_def_ovf", def_ovf, 0);
        check_eq("rst_def_in_ready", def_in_ready, 1);
        check_eq("rst_n8_valid", n8_out_valid, 0);
        check_eq("rst_sat_dout", sat_dout, 0);

        for (int i = 0; i < 10; i++) begin
            apply_vec(i);
        end

        run_backpressure();
        repeat (12) @(negedge clk);

        // Reset with transactions in flight; the reset cycle also presents an input.
        din0 = vecs[3].d0; din1 = vecs[3].d1; sgn = vecs[3].sg; in_valid = 1'b1;
        @(negedge clk);
        din0 = vecs[5].d0; din1 = vecs[5].d1; sgn = vecs[5].sg;
        @(negedge clk);
        din0 = vecs[0].d0; din1 = vecs[0].d1; sgn = vecs[0].sg;
        ap_rst = 1'b1;
        @(negedge clk);
        ap_rst   = 1'b0;
        in_valid = 1'b0;
        check_eq("mrst_def_valid", def_out_valid, 0);
        check_eq("mrst_def_dout", def_dout, 0);
        check_eq("mrst_def_in_ready", def_in_ready, 1);
        check_eq("mrst_n1_valid", n1_out_valid, 0);
        check_eq("mrst_n1_dout", n1_dout, 0);
        check_eq("mrst_n8_valid", n8_out_valid, 0);
        check_eq("mrst_n8_dout", n8_dout, 0);
        check_eq("mrst_n8_in_ready", n8_in_ready, 1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_eq("mrst_def_stale", def_out_valid, 0);
            check_eq("mrst_n1_stale", n1_out_valid, 0);
            check_eq("mrst_n8_stale", n8_out_valid, 0);
        end
        apply_vec(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/norm1_mul_pipe.md
Name: norm1_mul_pipe

Overview:
- Parametrised, pipelined successor to the norm1 18x18 combinational multiplier.
- Multiplies two operands with a per-transaction signed/unsigned mode, optional output saturation and an overflow flag.
- Pipeline depth is configurable, with a valid/ready handshake on both sides.
- Sits between the LRN normalisation datapath and its downstream scaling stage; takes backpressure from downstream.

Parameters:
- ID, 1, instance tag; no functional effect.
- NUM_STAGE, 3, pipeline depth in cycles, legal range 1..8.
- din0_WIDTH, 18, operand 0 width.
- din1_WIDTH, 18, operand 1 width.
- dout_WIDTH, 36, result width, legal range 2..din0_WIDTH+din1_WIDTH+2.
- SAT, 0, 0 = truncate to the low dout_WIDTH bits; 1 = saturate to the dout range.

Ports:
- ap_clk  in  1  clock; all state changes on the rising edge.
- ap_rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block can accept an input this cycle.
- din0  in  din0_WIDTH  operand 0.
- din1  in  din1_WIDTH  operand 1.
- sgn  in  1  1 = both operands two's complement; 0 = both unsigned.
- out_valid  out  1  dout/ovf hold a valid result.
- out_ready  in  1  downstream accepts the result.
- dout  out  dout_WIDTH  product.
- ovf  out  1  the full product did not fit in dout_WIDTH under the transaction's mode.

Behaviour:
- Reset: one ap_rst cycle clears every stage valid bit and every data register.
  - After reset: out_valid=0, dout=0, ovf=0, in_ready=1.
  - Reset mid-operation discards all in-flight transactions; nothing is emitted for them.
- Pipeline: NUM_STAGE register stages, each holding {valid, sgn, partial data}. The last stage drives out_valid/dout/ovf directly from registers, so there is no combinational path from inputs to outputs.
- Stall: stall = out_valid & ~out_ready.
  - When stall=1, every stage holds.
  - When stall=0, all stages shift by one; stage 0 captures in_valid & in_ready.
  - in_ready = ~stall. This is combinational from out_valid and out_ready only, never from in_valid.
  - Bubbles are not collapsed.
- Acceptance: an input is accepted when in_valid & in_ready. Its result reaches out_valid exactly NUM_STAGE cycles later, provided no stall occurs in between. Each stall cycle adds one cycle of latency.
- Ordering: results emerge in acceptance order; there are no drops and no duplicates.
- Hold: while out_valid & ~out_ready, dout, ovf and out_valid stay stable.
- Throughput: with out_ready held at 1, the block accepts one transaction per cycle.
- Arithmetic:
  - P = din0_WIDTH + din1_WIDTH.
  - sgn=1: sign-extend both operands. sgn=0: zero-extend both.
  - Form the exact P-bit product (signed when sgn=1).
  - If dout_WIDTH >= P: extend to dout_WIDTH by sign or zero according to sgn; ovf=0.
  - If dout_WIDTH < P and SAT=0: dout = low dout_WIDTH bits; ovf=1 when the discarded high bits are not a pure sign/zero extension of dout.
  - If dout_WIDTH < P and SAT=1, same ovf rule, and on overflow dout clamps:
    - signed: 2^(dout_WIDTH-1)-1 or -2^(dout_WIDTH-1);
    - unsigned: 2^dout_WIDTH-1.
- Retiming: the multiply may be split across stages freely; only the end-to-end result and latency are specified.
- Simultaneous events: when out_valid & out_ready & in_valid occur in the same cycle, accept and emit in that one cycle.
- ap_rst has priority over all handshakes.

Test Plan:
- Defaults, sgn=0, out_ready=1: din0=0x3FFFF, din1=0x3FFFF accepted at cycle t -> out_valid at t+3, dout=0xFFFF80001, ovf=0.
- Defaults, sgn=1: din0=0x20000 (-131072), din1=0x3FFFF (-1) -> dout=0x000020000 (+131072), ovf=0. Also din0=0x3FFFE (-2), din1=0x00003 -> dout=0xFFFFFFFFA.
- Backpressure: 5 back-to-back inputs with out_ready low for 4 cycles after the first out_valid -> in_ready low during the stall, dout held stable, all 5 results in order, none lost.
- dout_WIDTH=16, SAT=1:
  - sgn=1, 300*300 -> dout=0x7FFF, ovf=1.
  - sgn=0, 300*300 -> dout=0xFFFF, ovf=1.
  - sgn=1, 100*-100 -> dout=0xD8F0, ovf=0.
- Same input with SAT=0: sgn=0, 300*300 -> dout=0x5F90 (low 16 bits of 90000), ovf=1.
- Reset mid-flight: assert ap_rst for 1 cycle with 2 transactions in the pipe -> next cycle out_valid=0, dout=0, in_ready=1; no stale result emerges; a new input yields a correct result NUM_STAGE cycles after acceptance. Repeat for NUM_STAGE=1 and NUM_STAGE=8.
